scanner_seq_ctrl: RTL and testbench
===================================

// Module: scanner_seq_ctrl
// PURPOSE
//  Multi-field step-and-scan sequence controller, successor to the single-shot scanner FSM.
//  Sequences load -> calib -> align (with retry) -> per-field level/sync/expose/step loop -> unload.
//  Adds a per-state watchdog timeout, error codes and operator abort.
//  Sits between the host command interface and the stage/laser/chuck drivers.
// PARAMETERS
//  FIELD_W    8   width of field count/index (max 2^FIELD_W-1 fields per wafer)
//  TIMEOUT_W  16  width of per-state watchdog counter and timeout_limit
//  MAX_RETRY  2   align_fail retries allowed before ALIGN error
// PORTS
//  clk            in   1          system clock
//  reset_n        in   1          asynchronous, active-low reset
//  start_cmd      in   1          start wafer sequence (sampled in IDLE only)
//  abort_cmd      in   1          operator abort
//  num_fields     in   FIELD_W    fields to expose; latched on accepted start
//  timeout_limit  in   TIMEOUT_W  watchdog limit in cycles; 0 disables watchdog
//  mech_done      in   1          current mechanical step complete
//  align_fail     in   1          alignment measurement failed (ALIGN only)
//  focus_error    in   1          focus interlock
//  err_clear      in   1          leave ERROR
//  current_step   out  4          current state encoding
//  field_idx      out  FIELD_W    index of field being processed (0-based)
//  laser_on       out  1          laser trigger
//  vacuum_on      out  1          chuck vacuum
//  stage_move     out  1          stage motion enable
//  busy           out  1          state != IDLE and != ERROR
//  done_pulse     out  1          1-cycle pulse on normal completion
//  err_code       out  3          0 NONE, 1 FOCUS, 2 TIMEOUT, 3 ALIGN, 4 ABORT
// BEHAVIOUR
//  Reset: state=IDLE, field_idx=0, retry_cnt=0, watchdog=0, err_code=0; all outputs 0.
//  States: IDLE=0 LOAD=1 CALIB=2 ALIGN=3 LEVEL=4 SYNC=5 EXPOSE=6 STEP=7 UNLOAD=8 ERROR=15.
//  IDLE: start_cmd && num_fields!=0 -> LOAD; latch num_fields, field_idx=0, retry_cnt=0, err_code=0.
//   start_cmd with num_fields==0 is ignored.
//  LOAD->CALIB->ALIGN on mech_done. ALIGN: align_fail beats mech_done;
//   retry_cnt<MAX_RETRY -> retry_cnt++, stay ALIGN (watchdog restarts); else ERROR, code ALIGN.
//   mech_done -> LEVEL.
//  LEVEL->SYNC->EXPOSE on mech_done. EXPOSE mech_done: field_idx==nf-1 -> UNLOAD, else STEP.
//  STEP mech_done -> LEVEL, field_idx++ (re-level every field). UNLOAD mech_done -> IDLE.
//  Priority per cycle: focus_error > abort_cmd > watchdog expiry > align_fail > mech_done.
//  focus_error in LEVEL/SYNC/EXPOSE/STEP -> ERROR, code FOCUS; ignored elsewhere.
//  abort_cmd: LOAD -> IDLE; CALIB..STEP -> UNLOAD with abort flag set; ignored in IDLE/UNLOAD/ERROR.
//   Aborted UNLOAD completion -> IDLE, err_code=ABORT, no done_pulse.
//  Watchdog: cleared on every state entry (incl. ALIGN retry); counts in LOAD..UNLOAD;
//   count==timeout_limit (limit!=0) -> ERROR, code TIMEOUT. Counter saturates, never wraps.
//  ERROR: err_code held; err_clear -> IDLE (err_code kept until next accepted start).
//  done_pulse: one cycle, the cycle after a non-aborted UNLOAD mech_done (state==IDLE).
//  Outputs Moore-decoded from state register (change 1 cycle after condition sampled), except:
//   laser_on = (state==EXPOSE) & ~focus_error, combinational: drops same cycle as focus_error.
//  vacuum_on: CALIB..STEP and ERROR (wafer stays clamped on fault); 0 in IDLE/LOAD/UNLOAD.
//  stage_move: ALIGN..STEP; 0 in ERROR.
//  reset_n low mid-sequence: immediate return to reset values, laser/vacuum/stage off.
// STRUCTURE
//  scanner_pkg: state localparams, err_code constants, state-width constant.
//  Sub-module scanner_watchdog: TIMEOUT_W saturating counter, clear/enable in, expired out.
//  Top: next-state logic, field/retry counters, output decode.
// TESTING
//  1. num_fields=3, mech_done every 4 cycles -> EXPOSE visited 3x, field_idx 0,1,2, done_pulse once.
//  2. align_fail x2 then mech_done (MAX_RETRY=2) -> proceeds to LEVEL; align_fail x3 -> ERROR, code 3.
//  3. focus_error in EXPOSE of field 1 -> laser_on 0 same cycle, ERROR next, code 1, vacuum_on 1.
//  4. timeout_limit=10, no mech_done in SYNC -> ERROR exactly 10 cycles after entry, code 2; limit=0 never.
//  5. abort_cmd in LEVEL -> UNLOAD, mech_done -> IDLE, err_code 4, no done_pulse; abort in LOAD -> IDLE.
//  6. reset_n low in EXPOSE -> all outputs 0 async; start with num_fields=0 -> stays IDLE.

Source files
------------

// File: rtl/scanner_pkg.sv
// Shared state encoding, error codes and per-state output decode for the scanner sequencer.
package scanner_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ERR_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_CALIB  = 4'd2,
        ST_ALIGN  = 4'd3,
        ST_LEVEL  = 4'd4,
        ST_SYNC   = 4'd5,
        ST_EXPOSE = 4'd6,
        ST_STEP   = 4'd7,
        ST_UNLOAD = 4'd8,
        ST_ERROR  = 4'd15
    } state_t;

    localparam logic [ERR_W-1:0] ERR_NONE    = 3'd0;
    localparam logic [ERR_W-1:0] ERR_FOCUS   = 3'd1;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 3'd2;
    localparam logic [ERR_W-1:0] ERR_ALIGN   = 3'd3;
    localparam logic [ERR_W-1:0] ERR_ABORT   = 3'd4;

    // Per-field exposure loop states, where the focus interlock is armed.
    function automatic logic is_scan(state_t s);
        return (s inside {ST_LEVEL, ST_SYNC, ST_EXPOSE, ST_STEP});
    endfunction

    // Chuck keeps the wafer clamped through the whole exposure path and on faults.
    function automatic logic vacuum_of(state_t s);
        return (s inside {ST_CALIB, ST_ALIGN, ST_LEVEL, ST_SYNC, ST_EXPOSE, ST_STEP, ST_ERROR});
    endfunction

    // Stage is only enabled while aligning and stepping through fields.
    function automatic logic stage_of(state_t s);
        return (s inside {ST_ALIGN, ST_LEVEL, ST_SYNC, ST_EXPOSE, ST_STEP});
    endfunction

    // Any sequencing state counts as busy; idle and fault states do not.
    function automatic logic busy_of(state_t s);
        return !(s inside {ST_IDLE, ST_ERROR});
    endfunction

    // States in which the per-state watchdog runs.
    function automatic logic watched(state_t s);
        return (s inside {ST_LOAD, ST_CALIB, ST_ALIGN, ST_LEVEL, ST_SYNC,
                          ST_EXPOSE, ST_STEP, ST_UNLOAD});
    endfunction

endpackage

// File: rtl/scanner_watchdog.sv
// Per-state saturating dwell counter; flags expiry on the limit-th cycle spent in a state.
module scanner_watchdog #(
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expired_c
);

    localparam int unsigned CW = TIMEOUT_W + 1;

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] elapsed;

    // Cycles already spent in the state; first cycle after entry reads as zero.
    always_comb begin
        elapsed   = clear ? '0 : cnt_q;
        expired_c = enable && (limit != '0) &&
                    ((CW'(elapsed) + CW'(1)) == CW'(limit));
    end

    // Count while enabled, hold at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!enable) begin
            cnt_q <= '0;
        end else if (elapsed != '1) begin
            cnt_q <= elapsed + TIMEOUT_W'(1);
        end else begin
            cnt_q <= elapsed;
        end
    end

endmodule

// File: rtl/scanner_seq_ctrl.sv
// Multi-field step-and-scan sequencer: load, calib, align with retry, per-field loop, unload.
module scanner_seq_ctrl
    import scanner_pkg::*;
#(
    parameter int unsigned FIELD_W   = 8,
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_cmd,
    input  logic                 abort_cmd,
    input  logic [FIELD_W-1:0]   num_fields,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    input  logic                 mech_done,
    input  logic                 align_fail,
    input  logic                 focus_error,
    input  logic                 err_clear,
    output logic [STATE_W-1:0]   current_step,
    output logic [FIELD_W-1:0]   field_idx,
    output logic                 laser_on,
    output logic                 vacuum_on,
    output logic                 stage_move,
    output logic                 busy,
    output logic                 done_pulse,
    output logic [ERR_W-1:0]     err_code
);

    localparam int unsigned RETRY_W = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

    state_t               state_q, state_d;
    logic [FIELD_W-1:0]   nf_q, nf_d;
    logic [FIELD_W-1:0]   field_q, field_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 abort_q, abort_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 done_d;
    logic                 retry_restart;
    logic                 entering;
    logic                 fresh_q;
    logic                 wd_expired;

    scanner_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (fresh_q),
        .enable    (watched(state_q)),
        .limit     (timeout_limit),
        .expired_c (wd_expired)
    );

    // Next-state and counter update, priority focus > abort > watchdog > align_fail > mech_done.
    always_comb begin
        state_d       = state_q;
        nf_d          = nf_q;
        field_d       = field_q;
        retry_d       = retry_q;
        abort_d       = abort_q;
        err_d         = err_q;
        done_d        = 1'b0;
        retry_restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_cmd && (num_fields != '0)) begin
                    state_d = ST_LOAD;
                    nf_d    = num_fields;
                    field_d = '0;
                    retry_d = '0;
                    abort_d = 1'b0;
                    err_d   = ERR_NONE;
                end
            end
            ST_ERROR: begin
                if (err_clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (focus_error && is_scan(state_q)) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_FOCUS;
                end else if (abort_cmd && (state_q != ST_UNLOAD)) begin
                    if (state_q == ST_LOAD) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_UNLOAD;
                        abort_d = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                end else if ((state_q == ST_ALIGN) && align_fail) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d       = retry_q + RETRY_W'(1);
                        retry_restart = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_ALIGN;
                    end
                end else if (mech_done) begin
                    case (state_q)
                        ST_LOAD:   state_d = ST_CALIB;
                        ST_CALIB:  state_d = ST_ALIGN;
                        ST_ALIGN:  state_d = ST_LEVEL;
                        ST_LEVEL:  state_d = ST_SYNC;
                        ST_SYNC:   state_d = ST_EXPOSE;
                        ST_EXPOSE: state_d = (field_q == (nf_q - FIELD_W'(1))) ? ST_UNLOAD : ST_STEP;
                        ST_STEP: begin
                            state_d = ST_LEVEL;
                            field_d = field_q + FIELD_W'(1);
                        end
                        ST_UNLOAD: begin
                            state_d = ST_IDLE;
                            if (abort_q) begin
                                err_d = ERR_ABORT;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Every state entry, including an align retry, restarts the watchdog.
    assign entering = retry_restart || (state_d != state_q);

    // Laser gate drops in the same cycle the focus interlock trips.
    assign laser_on = (state_q == ST_EXPOSE) && !focus_error;

    assign field_idx = field_q;
    assign err_code  = err_q;

    // State, counters and Moore outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            nf_q         <= '0;
            field_q      <= '0;
            retry_q      <= '0;
            abort_q      <= 1'b0;
            err_q        <= ERR_NONE;
            fresh_q      <= 1'b0;
            done_pulse   <= 1'b0;
            current_step <= '0;
            vacuum_on    <= 1'b0;
            stage_move   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            nf_q         <= nf_d;
            field_q      <= field_d;
            retry_q      <= retry_d;
            abort_q      <= abort_d;
            err_q        <= err_d;
            fresh_q      <= entering;
            done_pulse   <= done_d;
            current_step <= state_d;
            vacuum_on    <= vacuum_of(state_d);
            stage_move   <= stage_of(state_d);
            busy         <= busy_of(state_d);
        end
    end

endmodule

// File: tb/tb_scanner_seq_ctrl.sv
// Bench for scanner_seq_ctrl: wafer-sequence list model, directed scenarios and random traffic.
module tb_scanner_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_cmd = 1'b0;
    logic        abort_cmd = 1'b0;
    logic [7:0]  num_fields = 8'd0;
    logic [15:0] timeout_limit = 16'd0;
    logic        mech_done = 1'b0;
    logic        align_fail = 1'b0;
    logic        focus_error = 1'b0;
    logic        err_clear = 1'b0;
    logic [3:0]  current_step;
    logic [7:0]  field_idx;
    logic        laser_on, vacuum_on, stage_move, busy, done_pulse;
    logic [2:0]  err_code;

    int n_checks = 0;
    int n_fail   = 0;

    scanner_seq_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_cmd     (start_cmd),
        .abort_cmd     (abort_cmd),
        .num_fields    (num_fields),
        .timeout_limit (timeout_limit),
        .mech_done     (mech_done),
        .align_fail    (align_fail),
        .focus_error   (focus_error),
        .err_clear     (err_clear),
        .current_step  (current_step),
        .field_idx     (field_idx),
        .laser_on      (laser_on),
        .vacuum_on     (vacuum_on),
        .stage_move    (stage_move),
        .busy          (busy),
        .done_pulse    (done_pulse),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A wafer run is the flat list of station codes it must visit; mech_done walks the list.
    int m_mode;      // 0 idle, 1 running, 2 fault
    int m_seq[$];
    int m_pos;
    bit m_abort;
    int m_err;
    int m_dwell;
    int m_retry;
    bit m_done;
    int m_fld;

    function automatic int exp_state();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 15;
        if (m_abort)     return 8;
        return m_seq[m_pos];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_abort = 0; m_err = 0;
        m_dwell = 0; m_retry = 0; m_done = 0; m_fld = 0;
        m_seq.delete();
    endtask

    task automatic to_fault(input int code);
        m_mode = 2;
        m_err  = code;
    endtask

    task automatic model_step();
        int cur;
        bit scan;
        cur  = exp_state();
        scan = (cur >= 4 && cur <= 7);
        m_done = 0;
        if (m_mode == 0) begin
            if (start_cmd && num_fields != 0) begin
                m_seq.delete();
                m_seq.push_back(1); m_seq.push_back(2); m_seq.push_back(3);
                for (int f = 0; f < int'(num_fields); f++) begin
                    m_seq.push_back(4); m_seq.push_back(5); m_seq.push_back(6);
                    if (f < int'(num_fields) - 1) m_seq.push_back(7);
                end
                m_seq.push_back(8);
                m_mode = 1; m_pos = 0; m_abort = 0; m_err = 0;
                m_retry = 0; m_fld = 0; m_dwell = 0;
            end
        end else if (m_mode == 2) begin
            if (err_clear) m_mode = 0;
        end else begin
            if (focus_error && scan) begin
                to_fault(1);
            end else if (abort_cmd && cur != 8) begin
                if (cur == 1) m_mode = 0;
                else begin m_abort = 1; m_dwell = 0; end
            end else if (timeout_limit != 0 && m_dwell + 1 == int'(timeout_limit)) begin
                to_fault(2);
            end else if (cur == 3 && align_fail) begin
                if (m_retry < 2) begin m_retry++; m_dwell = 0; end
                else to_fault(3);
            end else if (mech_done) begin
                if (cur == 8) begin
                    m_mode = 0;
                    if (m_abort) m_err = 4; else m_done = 1;
                end else begin
                    m_pos++;
                    m_dwell = 0;
                    m_fld = 0;
                    for (int i = 0; i < m_pos; i++) if (m_seq[i] == 7) m_fld++;
                end
            end else begin
                m_dwell++;
            end
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // Compare every output against the model once per cycle, mid-period.
    always @(negedge clk) begin
        int es;
        es = exp_state();
        check("current_step", 32'(current_step), 32'(es));
        check("field_idx",    32'(field_idx),    32'(m_fld));
        check("err_code",     32'(err_code),     32'(m_err));
        check("busy",         32'(busy),         32'(m_mode == 1));
        check("done_pulse",   32'(done_pulse),   32'(m_done));
        check("vacuum_on",    32'(vacuum_on),    32'((es >= 2 && es <= 7) || es == 15));
        check("stage_move",   32'(stage_move),   32'(es >= 3 && es <= 7));
        check("laser_on",     32'(laser_on),     32'(es == 6 && !focus_error));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_run(input int nf);
        num_fields = 8'(nf);
        start_cmd  = 1'b1;
        tick();
        start_cmd  = 1'b0;
    endtask

    task automatic pulse_md(input int n);
        for (int i = 0; i < n; i++) begin
            mech_done = 1'b1; tick();
            mech_done = 1'b0; tick();
        end
    endtask

    initial begin
        int vis, dn, prev, first;
        int flds[8];

        // Reset values
        reset_n = 1'b0;
        tick(); tick();
        check("rst_step", 32'(current_step), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err",  32'(err_code), 0);
        reset_n = 1'b1;
        tick();

        // Three fields, mech_done every 4 cycles
        start_run(3);
        vis = 0; dn = 0; prev = 1;
        for (int c = 0; c < 80; c++) begin
            mech_done = (c % 4 == 3);
            tick();
            if (current_step == 4'd6 && prev != 6) begin
                if (vis < 8) flds[vis] = int'(field_idx);
                vis++;
            end
            prev = int'(current_step);
            if (done_pulse) dn++;
        end
        mech_done = 1'b0;
        check("t1_expose_visits", 32'(vis), 3);
        check("t1_done_count",    32'(dn), 1);
        check("t1_field0", 32'(flds[0]), 0);
        check("t1_field1", 32'(flds[1]), 1);
        check("t1_field2", 32'(flds[2]), 2);

        // Two align retries then success; three failures fault
        start_run(1);
        pulse_md(2);
        for (int k = 0; k < 2; k++) begin
            align_fail = 1'b1; tick(); align_fail = 1'b0; tick();
        end
        check("t2_still_align", 32'(current_step), 3);
        pulse_md(1);
        check("t2_level", 32'(current_step), 4);
        pulse_md(4);
        check("t2_idle", 32'(current_step), 0);
        start_run(1);
        pulse_md(2);
        align_fail = 1'b1;
        tick(); tick(); tick();
        align_fail = 1'b0;
        check("t2_err_state", 32'(current_step), 15);
        check("t2_err_code",  32'(err_code), 3);
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        check("t2_err_kept", 32'(err_code), 3);

        // Focus interlock in EXPOSE of field 1
        start_run(2);
        pulse_md(9);
        check("t3_expose",  32'(current_step), 6);
        check("t3_field",   32'(field_idx), 1);
        check("t3_laser",   32'(laser_on), 1);
        focus_error = 1'b1;
        #1;
        check("t3_laser_drop", 32'(laser_on), 0);
        tick();
        focus_error = 1'b0;
        check("t3_err_state", 32'(current_step), 15);
        check("t3_err_code",  32'(err_code), 1);
        check("t3_vacuum",    32'(vacuum_on), 1);
        err_clear = 1'b1; tick(); err_clear = 1'b0;

        // Watchdog of 10 cycles in SYNC
        timeout_limit = 16'd10;
        start_run(1);
        pulse_md(3);
        mech_done = 1'b1; tick(); mech_done = 1'b0;
        check("t4_sync", 32'(current_step), 5);
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (current_step == 4'd15 && first < 0) first = i;
        end
        check("t4_timeout_cycles", 32'(first), 10);
        check("t4_err_code",       32'(err_code), 2);
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        timeout_limit = 16'd0;
        start_run(1);
        pulse_md(4);
        repeat (50) tick();
        check("t4_no_timeout", 32'(current_step), 5);

        // Abort from SYNC, then from LEVEL, then from LOAD
        abort_cmd = 1'b1; tick(); abort_cmd = 1'b0;
        check("t5_unload", 32'(current_step), 8);
        pulse_md(1);
        check("t5_abort_code", 32'(err_code), 4);
        start_run(2);
        pulse_md(3);
        check("t5_level", 32'(current_step), 4);
        abort_cmd = 1'b1; tick(); abort_cmd = 1'b0;
        check("t5_unload2", 32'(current_step), 8);
        mech_done = 1'b1; tick(); mech_done = 1'b0;
        check("t5_idle",    32'(current_step), 0);
        check("t5_no_done", 32'(done_pulse), 0);
        check("t5_code",    32'(err_code), 4);
        start_run(2);
        abort_cmd = 1'b1; tick(); abort_cmd = 1'b0;
        check("t5_load_abort", 32'(current_step), 0);
        check("t5_load_busy",  32'(busy), 0);

        // Asynchronous reset mid-exposure, then zero-field start ignored
        start_run(1);
        pulse_md(5);
        check("t6_expose", 32'(laser_on), 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_step",  32'(current_step), 0);
        check("t6_rst_laser", 32'(laser_on), 0);
        check("t6_rst_vac",   32'(vacuum_on), 0);
        check("t6_rst_stage", 32'(stage_move), 0);
        tick();
        reset_n = 1'b1;
        tick();
        start_run(0);
        tick();
        check("t6_zero_fields", 32'(current_step), 0);
        check("t6_zero_busy",   32'(busy), 0);

        // Random traffic against the model
        for (int blk = 0; blk < 20; blk++) begin
            timeout_limit = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(3, 14));
            for (int c = 0; c < 200; c++) begin
                start_cmd   = ($urandom_range(0, 3) == 0);
                num_fields  = 8'($urandom_range(0, 4));
                mech_done   = ($urandom_range(0, 2) == 0);
                align_fail  = ($urandom_range(0, 5) == 0);
                focus_error = ($urandom_range(0, 49) == 0);
                abort_cmd   = ($urandom_range(0, 59) == 0);
                err_clear   = ($urandom_range(0, 4) == 0);
                reset_n     = ($urandom_range(0, 299) != 0);
                tick();
            end
        end
        start_cmd = 1'b0; mech_done = 1'b0; align_fail = 1'b0; focus_error = 1'b0;
        abort_cmd = 1'b0; err_clear = 1'b0; reset_n = 1'b1;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
